// File: rtl/pe_pkg.sv
`default_nettype none
//============================================================================
// Module      : pe_pkg
// Description : Shared definitions for the PE stream feeder: FSM state
//               encoding and skid-buffer depth.
// Revision    : 1.0 - initial release
//============================================================================
package pe_pkg;

    // Words that may be buffered plus in flight from the SRAM at any time.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/feeder_skid_fifo.sv
`default_nettype none
//============================================================================
// Module      : feeder_skid_fifo
// Description : 2-entry synchronous FIFO that absorbs the SRAM read latency
//               in front of the PE input. A simultaneous push and pop leaves
//               the count unchanged.
// Ports       : clk, rst_n (async, active low)
//               i_push / i_din   - write one word
//               i_pop            - remove the head word
//               o_dout           - head word (register output)
//               o_count[1:0]     - words currently held
// Revision    : 1.0 - initial release
//============================================================================
module feeder_skid_fifo
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_do_push = i_push && ((r_count != 2'(SKID_DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pe_stream_feeder.sv
`default_nettype none
//============================================================================
// Module      : pe_stream_feeder
// Description : Streams a run of words from a global-buffer SRAM (1-cycle
//               read latency) into one PE input FIFO, honouring the PE full
//               flag. At most two words are buffered or in flight, held in
//               a 2-entry skid buffer, so no word is ever dropped.
// Ports       : clk, rst_n (async, active low)
//               i_start, i_base_addr, i_length - transfer request (pulse)
//               i_stride      - address increment (FEEDER_STRIDE_EN only)
//               o_busy, o_done                 - transfer status
//               o_rd_en, o_rd_addr, i_rd_data  - SRAM read port
//               i_pe_full                      - PE backpressure
//               o_data_out, o_data_en          - word to the PE
// Config      : `define FEEDER_STRIDE_EN adds i_stride, latched at start;
//               otherwise the address advances by 1 per read.
// Revision    : 1.0 - initial release
//============================================================================
module pe_stream_feeder
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_length,
`ifdef FEEDER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] i_stride,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_pe_full,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_en
);

    feeder_state_t         r_state;
    feeder_state_t         w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH:0]    r_issued;
    logic [LEN_WIDTH:0]    r_sent;
    logic [LEN_WIDTH:0]    w_len_ext;
    logic [LEN_WIDTH:0]    w_issued_nxt;
    logic [LEN_WIDTH:0]    w_sent_nxt;
    logic                  r_inflight;
    logic [1:0]            w_count;
    logic [2:0]            w_occ;
    logic                  w_accept;
    logic                  w_rd_en;
    logic                  w_pop;

`ifdef FEEDER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] r_stride;
    assign w_incr = r_stride;
`else
    assign w_incr = ADDR_WIDTH'(1);
`endif

    assign w_accept  = (r_state == ST_IDLE) && i_start;
    assign w_pop     = !i_pe_full && (w_count != 2'd0);
    // Occupancy after this cycle's pop; counting the pop lets a new read
    // issue every cycle, giving one word per cycle while the PE keeps up.
    assign w_occ     = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_len_ext = {1'b0, r_len};
    assign w_rd_en   = (r_state == ST_RUN) && (r_issued < w_len_ext)
                       && (w_occ < 3'(SKID_DEPTH));
    assign w_issued_nxt = r_issued + {{LEN_WIDTH{1'b0}}, w_rd_en};
    assign w_sent_nxt   = r_sent + {{LEN_WIDTH{1'b0}}, w_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_length == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_issued_nxt == w_len_ext) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                // Leave as the last word is accepted so done follows it directly.
                if (w_sent_nxt == w_len_ext) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_sent     <= '0;
            r_inflight <= 1'b0;
`ifdef FEEDER_STRIDE_EN
            r_stride   <= '0;
`endif
        end else begin
            // Data for a read issued this cycle arrives next cycle.
            r_inflight <= w_rd_en;
            if (w_accept) begin
                r_addr   <= i_base_addr;
                r_len    <= i_length;
                r_issued <= '0;
                r_sent   <= '0;
`ifdef FEEDER_STRIDE_EN
                r_stride <= i_stride;
`endif
            end else begin
                if (w_rd_en) begin
                    r_addr   <= r_addr + w_incr;
                    r_issued <= w_issued_nxt;
                end
                if (w_pop) begin
                    r_sent <= w_sent_nxt;
                end
            end
        end
    end

    feeder_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_din   (i_rd_data),
        .i_pop   (w_pop),
        .o_dout  (o_data_out),
        .o_count (w_count)
    );

    assign o_rd_en   = w_rd_en;
    assign o_rd_addr = r_addr;
    assign o_data_en = w_pop;

endmodule
`default_nettype wire

// File: tb/tb_pe_stream_feeder.sv
`default_nettype none
//============================================================================
// Module      : tb_pe_stream_feeder
// Description : Self-checking bench for pe_stream_feeder. A transfer-level
//               model (expected address/data sequence, occupancy bound,
//               done timing) is compared every cycle; literal expectations
//               pin key transfers. Build with FEEDER_STRIDE_EN to add the
//               stride transfer.
// Revision    : 1.0 - initial release
//============================================================================
module tb_pe_stream_feeder;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [LW-1:0] i_length;
    logic [AW-1:0] tb_stride;
    logic          o_busy;
    logic          o_done;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [DW-1:0] i_rd_data;
    logic          i_pe_full;
    logic [DW-1:0] o_data_out;
    logic          o_data_en;

    pe_stream_feeder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_length    (i_length),
`ifdef FEEDER_STRIDE_EN
        .i_stride    (tb_stride),
`endif
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .i_pe_full   (i_pe_full),
        .o_data_out  (o_data_out),
        .o_data_en   (o_data_en)
    );

    always #5 clk = ~clk;

    // Global-buffer SRAM: mem[i] = i, data valid the cycle after the read.
    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    end
    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= mem[o_rd_addr];
    end

    // Checking state
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int tag    = 0;
    bit m_active = 1'b0;
    int m_base, m_len, m_stride;
    int rd_idx, sent_idx, start_cyc, first_rd, first_en, done_due, active_cnt;
    logic [DW-1:0] cap_data [$];
    int            cap_addr [$];

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        int exp_a;
        bit exp_busy;
        bit exp_done;
        cyc++;
        if (!rst_n) begin
            chk(o_busy == 1'b0,     "rst_busy",     longint'(o_busy),     0);
            chk(o_done == 1'b0,     "rst_done",     longint'(o_done),     0);
            chk(o_rd_en == 1'b0,    "rst_rd_en",    longint'(o_rd_en),    0);
            chk(o_rd_addr == '0,    "rst_rd_addr",  longint'(o_rd_addr),  0);
            chk(o_data_out == '0,   "rst_data_out", longint'(o_data_out), 0);
            chk(o_data_en == 1'b0,  "rst_data_en",  longint'(o_data_en),  0);
            m_active = 1'b0;
        end else begin
            if (!m_active && i_start) begin
                m_active   = 1'b1;
                m_base     = int'(i_base_addr);
                m_len      = int'(i_length);
                m_stride   = int'(tb_stride);
                rd_idx     = 0;
                sent_idx   = 0;
                start_cyc  = cyc;
                first_rd   = -1;
                first_en   = -1;
                active_cnt = 0;
                done_due   = (m_len == 0) ? cyc + 1 : -1;
                cap_data.delete();
                cap_addr.delete();
            end
            exp_busy = m_active && (cyc > start_cyc);
            chk(o_busy == exp_busy, "busy", longint'(o_busy), longint'(exp_busy));
            if (o_data_en) begin
                chk(!i_pe_full, "data_en_while_full", longint'(o_data_en), 0);
                chk(m_active && (sent_idx < rd_idx), "data_en_window", sent_idx, rd_idx);
                exp_a = (m_base + sent_idx * m_stride) % 256;
                chk(o_data_out == mem[exp_a[7:0]], "data_out", longint'(o_data_out),
                    longint'(mem[exp_a[7:0]]));
                cap_data.push_back(o_data_out);
                if (first_en < 0) first_en = cyc;
                sent_idx++;
                if (m_active && sent_idx == m_len) done_due = cyc + 1;
            end
            if (o_rd_en) begin
                chk(m_active && (cyc > start_cyc) && (rd_idx < m_len), "rd_en_window", rd_idx, m_len);
                exp_a = (m_base + rd_idx * m_stride) % 256;
                chk(int'(o_rd_addr) == exp_a, "rd_addr", longint'(o_rd_addr), exp_a);
                cap_addr.push_back(int'(o_rd_addr));
                if (first_rd < 0) first_rd = cyc;
                rd_idx++;
                chk((rd_idx - sent_idx) <= 2, "occupancy", rd_idx - sent_idx, 2);
            end
            exp_done = m_active && (done_due == cyc);
            if (o_done || exp_done) begin
                chk(o_done == exp_done, "done", longint'(o_done), longint'(exp_done));
            end
            if (exp_done) begin
                chk(rd_idx == m_len, "reads_total", rd_idx, m_len);
                case (tag)
                    1: begin
                        chk(first_rd - start_cyc == 1, "t1_first_rd_lat", first_rd - start_cyc, 1);
                        chk(first_en - start_cyc == 3, "t1_first_en_lat", first_en - start_cyc, 3);
                        chk(cyc - start_cyc == 9, "t1_done_lat", cyc - start_cyc, 9);
                        chk(cap_data.size() == 6, "t1_words", cap_data.size(), 6);
                        chk((cap_data.size() == 6) && (cap_data[0] == 16'h0010), "t1_word0",
                            (cap_data.size() > 0) ? longint'(cap_data[0]) : -1, 16'h0010);
                        chk((cap_data.size() == 6) && (cap_data[5] == 16'h0015), "t1_word5",
                            (cap_data.size() > 5) ? longint'(cap_data[5]) : -1, 16'h0015);
                    end
                    2: begin
                        chk(cap_data.size() == 6, "t2_words", cap_data.size(), 6);
                        for (int k = 0; k < cap_data.size(); k++)
                            chk(cap_data[k] == DW'(16 + k), "t2_order", longint'(cap_data[k]), 16 + k);
                    end
                    3: begin
                        chk(cap_addr.size() == 4, "t3_reads", cap_addr.size(), 4);
                        if (cap_addr.size() == 4) begin
                            chk(cap_addr[0] == 'hFE, "t3_addr0", cap_addr[0], 'hFE);
                            chk(cap_addr[1] == 'hFF, "t3_addr1", cap_addr[1], 'hFF);
                            chk(cap_addr[2] == 'h00, "t3_addr2", cap_addr[2], 'h00);
                            chk(cap_addr[3] == 'h01, "t3_addr3", cap_addr[3], 'h01);
                        end
                    end
                    4: begin
                        chk(cyc - start_cyc == 1, "t4_done_lat", cyc - start_cyc, 1);
                        chk(rd_idx == 0, "t4_no_reads", rd_idx, 0);
                    end
                    5: begin
                        chk(cap_data.size() == 6, "t5_words", cap_data.size(), 6);
                        chk((cap_addr.size() == 6) && (cap_addr[5] == 'h25), "t5_last_addr",
                            (cap_addr.size() > 5) ? cap_addr[5] : -1, 'h25);
                    end
                    6: begin
                        chk(cap_data.size() == 3, "t6_words", cap_data.size(), 3);
                        chk((cap_data.size() == 3) && (cap_data[2] == 16'h0052), "t6_word2",
                            (cap_data.size() > 2) ? longint'(cap_data[2]) : -1, 16'h0052);
                    end
                    7: begin
                        chk(cap_addr.size() == 4, "t7_reads", cap_addr.size(), 4);
                        if (cap_addr.size() == 4) begin
                            chk(cap_addr[1] == 3, "t7_addr1", cap_addr[1], 3);
                            chk(cap_addr[3] == 9, "t7_addr3", cap_addr[3], 9);
                        end
                    end
                    8: begin
                        chk(cap_data.size() == 255, "t8_words", cap_data.size(), 255);
                        chk(cyc - start_cyc == 258, "t8_done_lat", cyc - start_cyc, 258);
                        if (cap_addr.size() == 255) begin
                            chk(cap_addr[127] == 'hFF, "t8_addr127", cap_addr[127], 'hFF);
                            chk(cap_addr[128] == 'h00, "t8_addr128", cap_addr[128], 'h00);
                        end
                    end
                    default: ;
                endcase
                m_active = 1'b0;
            end else if (m_active) begin
                active_cnt++;
                if (active_cnt > 1000) begin
                    chk(1'b0, "transfer_timeout", active_cnt, 1000);
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic start_xfer(input logic [7:0] b, input logic [7:0] l, input logic [7:0] s);
        @(posedge clk); #1;
        i_start     = 1'b1;
        i_base_addr = b;
        i_length    = l;
        tb_stride   = s;
        @(posedge clk); #1;
        i_start     = 1'b0;
    endtask

    // Waits for the model to close the transfer; optionally pulses start
    // during the done cycle, which the feeder must ignore.
    task automatic wait_idle(input bit start_in_done);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (start_in_done && o_done) begin
                i_start     = 1'b1;
                i_base_addr = 8'h70;
                i_length    = 8'd2;
                @(posedge clk); #1;
                i_start     = 1'b0;
            end
            if (!m_active) break;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int n);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (sent_idx >= n) break;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_length    = '0;
        i_pe_full   = 1'b0;
        tb_stride   = 8'd1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        tag = 1; start_xfer(8'h10, 8'd6, 8'd1); wait_idle(1'b1);

        tag = 2; start_xfer(8'h10, 8'd6, 8'd1);
        wait_words(2);
        i_pe_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 i_pe_full = 1'b0;
        wait_idle(1'b0);

        tag = 3; start_xfer(8'hFE, 8'd4, 8'd1); wait_idle(1'b0);

        tag = 4; start_xfer(8'h33, 8'd0, 8'd1); wait_idle(1'b0);

        tag = 5; start_xfer(8'h20, 8'd6, 8'd1);
        wait_words(3);
        i_start = 1'b1; i_base_addr = 8'h40; i_length = 8'd6;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_idle(1'b0);

        tag = 9; start_xfer(8'h30, 8'd6, 8'd1);
        wait_words(3);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tag = 6; start_xfer(8'h50, 8'd3, 8'd1); wait_idle(1'b0);

`ifdef FEEDER_STRIDE_EN
        tag = 7; start_xfer(8'h00, 8'd4, 8'd3); wait_idle(1'b0);
`endif

        tag = 8; start_xfer(8'h80, 8'd255, 8'd1); wait_idle(1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
